// File: rtl/rotor_if.sv
// Handshake and control bundle for one rotor stage: position control, wiring
// writes, and the independent forward/reverse substitution paths.
interface rotor_if #(
  parameter int SYM_W = 6
);
  logic             load_pos;
  logic [SYM_W-1:0] pos_in;
  logic             step_in;
  logic             carry_out;
  logic [SYM_W-1:0] position;
  logic             wr_en;
  logic [SYM_W-1:0] wr_addr;
  logic [SYM_W-1:0] wr_data;
  logic             fwd_valid;
  logic [SYM_W-1:0] fwd_in;
  logic             fwd_vout;
  logic [SYM_W-1:0] fwd_out;
  logic             rev_valid;
  logic [SYM_W-1:0] rev_in;
  logic             rev_vout;
  logic [SYM_W-1:0] rev_out;

  modport master (
    output load_pos, pos_in, step_in, wr_en, wr_addr, wr_data,
           fwd_valid, fwd_in, rev_valid, rev_in,
    input  carry_out, position, fwd_vout, fwd_out, rev_vout, rev_out
  );

  modport slave (
    input  load_pos, pos_in, step_in, wr_en, wr_addr, wr_data,
           fwd_valid, fwd_in, rev_valid, rev_in,
    output carry_out, position, fwd_vout, fwd_out, rev_vout, rev_out
  );
endinterface

// File: rtl/rotor_stage.sv
// Stepping Enigma rotor: programmable wiring with a shadow inverse table,
// ring setting, turnover carry and registered forward/reverse lookups.
module rotor_stage #(
  parameter int N_SYM = 26,
  parameter int SYM_W = 6,
  parameter int NOTCH = 16,
  parameter int RING  = 0
) (
  input logic clk,
  input logic rst_n,
  rotor_if.slave rif
);

  localparam int               DEPTH    = 1 << SYM_W;
  localparam int               MAX_FOLD = (DEPTH - 1) / N_SYM;
  localparam logic [SYM_W:0]   N_W      = (SYM_W+1)'(N_SYM);
  localparam logic [SYM_W-1:0] NOTCH_S  = SYM_W'(NOTCH);
  localparam logic [SYM_W-1:0] RING_S   = SYM_W'(RING);
  localparam logic [8*26-1:0]  ROTOR_I  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

  // Tables span the full index space so any SYM_W-bit index is legal; only
  // entries below N_SYM are ever written or read, the rest stay constant.
  logic [SYM_W-1:0] w_q    [DEPTH];
  logic [SYM_W-1:0] w_d    [DEPTH];
  logic [SYM_W-1:0] winv_q [DEPTH];
  logic [SYM_W-1:0] winv_d [DEPTH];

  logic [SYM_W-1:0] pos_q, pos_d;
  logic [SYM_W-1:0] off;
  logic [SYM_W-1:0] fwd_idx, rev_idx;
  logic             fwd_vout_q, fwd_vout_d;
  logic             rev_vout_q, rev_vout_d;
  logic [SYM_W-1:0] fwd_out_q, fwd_out_d;
  logic [SYM_W-1:0] rev_out_q, rev_out_d;
  logic             wr_ok;

  function automatic logic [SYM_W-1:0] mod_reduce(input logic [SYM_W-1:0] x);
    logic [SYM_W:0] r;
    r = {1'b0, x};
    for (int k = 0; k < MAX_FOLD; k++) begin
      if (r >= N_W) r = r - N_W;
    end
    return r[SYM_W-1:0];
  endfunction

  function automatic logic [SYM_W-1:0] mod_add(input logic [SYM_W-1:0] a,
                                               input logic [SYM_W-1:0] b);
    logic [SYM_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= N_W) t = t - N_W;
    return t[SYM_W-1:0];
  endfunction

  function automatic logic [SYM_W-1:0] mod_sub(input logic [SYM_W-1:0] a,
                                               input logic [SYM_W-1:0] b);
    logic [SYM_W:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (t[SYM_W]) t = t + N_W;
    return t[SYM_W-1:0];
  endfunction

  function automatic logic [SYM_W-1:0] dflt_fwd(input int i);
    logic [7:0] ch;
    if (N_SYM == 26 && i < 26) begin
      ch = 8'(ROTOR_I >> (8 * (25 - i)));
      return SYM_W'(ch - 8'd65);
    end
    return SYM_W'(i);
  endfunction

  function automatic logic [SYM_W-1:0] dflt_inv(input int i);
    logic [SYM_W-1:0] r;
    r = SYM_W'(i);
    for (int j = 0; j < N_SYM; j++) begin
      if (dflt_fwd(j) == SYM_W'(i)) r = SYM_W'(j);
    end
    return r;
  endfunction

  // Offset uses the post-step position so a step and a lookup in the same
  // cycle encrypt at the new position.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    pos_d = pos_q;
    if (rif.load_pos) begin
      pos_d = mod_reduce(rif.pos_in);
    end else if (rif.step_in) begin
      pos_d = ({1'b0, pos_q} == N_W - 1'b1) ? '0 : pos_q + SYM_W'(1);
    end

    off     = mod_sub(pos_d, RING_S);
    fwd_idx = mod_add(mod_reduce(rif.fwd_in), off);
    rev_idx = mod_add(mod_reduce(rif.rev_in), off);

    fwd_vout_d = rif.fwd_valid;
    rev_vout_d = rif.rev_valid;
    fwd_out_d  = rif.fwd_valid ? mod_sub(w_q[fwd_idx], off)    : fwd_out_q;
    rev_out_d  = rif.rev_valid ? mod_sub(winv_q[rev_idx], off) : rev_out_q;
  end

  assign wr_ok = rif.wr_en && ({1'b0, rif.wr_addr} < N_W)
                           && ({1'b0, rif.wr_data} < N_W);

  always_comb begin
    w_d    = w_q;
    winv_d = winv_q;
    if (wr_ok) begin
      w_d[rif.wr_addr]    = rif.wr_data;
      winv_d[rif.wr_data] = rif.wr_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      fwd_vout_q <= 1'b0;
      rev_vout_q <= 1'b0;
      fwd_out_q  <= '0;
      rev_out_q  <= '0;
    end else begin
      pos_q      <= pos_d;
      fwd_vout_q <= fwd_vout_d;
      rev_vout_q <= rev_vout_d;
      fwd_out_q  <= fwd_out_d;
      rev_out_q  <= rev_out_d;
    end
  end

  // NOTE: the wiring tables are reset on purpose: a reset must restore the
  // default rotor, so these cannot be mapped to reset-less RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_q[i]    <= dflt_fwd(i);
        winv_q[i] <= dflt_inv(i);
      end
    end else begin
      w_q    <= w_d;
      winv_q <= winv_d;
    end
  end

  assign rif.carry_out = rif.step_in && (pos_q == NOTCH_S) && !rif.load_pos;
  assign rif.position  = pos_q;
  assign rif.fwd_vout  = fwd_vout_q;
  assign rif.rev_vout  = rev_vout_q;
  assign rif.fwd_out   = fwd_out_q;
  assign rif.rev_out   = rev_out_q;

endmodule
